// File: rtl/pe_array_feeder.sv
// pe_array_feeder: activation feeder for the systolic PE array.
// Accepts k_len activation vectors over a valid/ready stream and skews them
// so row i reaches the array i cycles after row 0. It also sequences the
// array's load strobe and MAC enable around each job.
module pe_array_feeder #(
  parameter int ARRAY_SIZE         = 2,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int K_WIDTH            = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [K_WIDTH-1:0]            k_len,
  input  logic                          vec_valid,
  input  logic [COMPUTE_DATA_WIDTH-1:0] vec_data [ARRAY_SIZE],
  output logic                          vec_ready,
  output logic [COMPUTE_DATA_WIDTH-1:0] ins      [ARRAY_SIZE],
  output logic                          compute,
  output logic                          load_en,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  // Drain runs long enough to flush the deepest skew lane and let the
  // trailing partial sums ripple through the array.
  localparam int                 DRAIN_W    = $clog2(2 * ARRAY_SIZE) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * ARRAY_SIZE - 1);

  state_e               state_q, state_d;
  logic [K_WIDTH-1:0]   k_rem_q, k_rem_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 compute_q, load_en_q;
  logic                 hs;

  // vec_ready depends on state alone, so upstream valid never loops back.
  assign vec_ready = (state_q == S_STREAM);
  assign hs        = vec_valid & vec_ready;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign compute   = compute_q;
  assign load_en   = load_en_q;

  // Control state, remaining-vector count, drain count and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_rem_q   <= '0;
      drain_q   <= '0;
      compute_q <= 1'b0;
      load_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_rem_q   <= k_rem_d;
      drain_q   <= drain_d;
      // Strobes are registered from the next state so they line up with it.
      compute_q <= (state_d == S_STREAM) || (state_d == S_DRAIN);
      load_en_q <= (state_d == S_LOAD);
    end
  end

  // Next-state logic: job sequencing and vector/drain counting.
  always_comb begin
    state_d = state_q;
    k_rem_d = k_rem_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_rem_d = k_len;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        drain_d = '0;
        state_d = (k_rem_q != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        // k_rem is at least 1 here, so the decrement cannot wrap.
        if (hs) begin
          k_rem_d = k_rem_q - K_WIDTH'(1);
          if (k_rem_q == K_WIDTH'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Skew lanes: lane i is i+1 registers deep; bubbles and idle cycles shift zeros.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [COMPUTE_DATA_WIDTH-1:0] lane_q [0:i];

    // Shift the lane by one each cycle, inserting the handshaken element or zero.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int j = 0; j <= i; j++) begin
          lane_q[j] <= '0;
        end
      end else begin
        lane_q[0] <= hs ? vec_data[i] : '0;
        for (int j = 1; j <= i; j++) begin
          lane_q[j] <= lane_q[j-1];
        end
      end
    end

    assign ins[i] = lane_q[i];
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder (ARRAY_SIZE=2, 4-bit data, K_WIDTH=8).
// Each scenario fills a per-cycle stimulus table, runs it, records a trace,
// then compares packed traces with hand-computed expectations.
module tb_pe_array_feeder;
  localparam int AS   = 2;
  localparam int DW   = 4;
  localparam int KW   = 8;
  localparam int MAXC = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          vec_valid;
  logic [DW-1:0] vec_data [AS];
  logic          vec_ready;
  logic [DW-1:0] ins      [AS];
  logic          compute;
  logic          load_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pe_array_feeder #(
    .ARRAY_SIZE(AS),
    .COMPUTE_DATA_WIDTH(DW),
    .K_WIDTH(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .k_len(k_len),
    .vec_valid(vec_valid),
    .vec_data(vec_data),
    .vec_ready(vec_ready),
    .ins(ins),
    .compute(compute),
    .load_en(load_en),
    .busy(busy),
    .done(done)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Stimulus tables, indexed by cycle (cycle 0 = first cycle of a run).
  logic          st_v [MAXC];
  logic [KW-1:0] kl_v [MAXC];
  logic          vv_v [MAXC];
  logic [DW-1:0] d0_v [MAXC];
  logic [DW-1:0] d1_v [MAXC];
  logic          rs_v [MAXC];

  // Recorded trace.
  logic [DW-1:0] t_ins0 [MAXC];
  logic [DW-1:0] t_ins1 [MAXC];
  logic          t_cmp  [MAXC];
  logic          t_ld   [MAXC];
  logic          t_rdy  [MAXC];
  logic          t_busy [MAXC];
  logic          t_done [MAXC];
  int            hs_cnt, hs_first, hs_last;

  // Packed views of cycles 0..15: bit c / nibble c belongs to cycle c.
  logic [15:0] m_cmp, m_ld, m_rdy, m_busy, m_done;
  logic [63:0] p_ins0, p_ins1;

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_v[i] = 1'b0;
      kl_v[i] = '0;
      vv_v[i] = 1'b0;
      d0_v[i] = '0;
      d1_v[i] = '0;
      rs_v[i] = 1'b1;
    end
  endtask

  // Expects to be called 1 time unit after a rising edge.
  task automatic run(input int ncyc);
    hs_cnt   = 0;
    hs_first = -1;
    hs_last  = -1;
    for (int c = 0; c < ncyc; c++) begin
      start       = st_v[c];
      k_len       = kl_v[c];
      vec_valid   = vv_v[c];
      vec_data[0] = d0_v[c];
      vec_data[1] = d1_v[c];
      rst         = rs_v[c];
      #1;
      t_ins0[c] = ins[0];
      t_ins1[c] = ins[1];
      t_cmp[c]  = compute;
      t_ld[c]   = load_en;
      t_rdy[c]  = vec_ready;
      t_busy[c] = busy;
      t_done[c] = done;
      if (vec_valid && vec_ready && rst) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    vec_valid = 1'b0;
    rst       = 1'b1;
    m_cmp = '0; m_ld = '0; m_rdy = '0; m_busy = '0; m_done = '0;
    p_ins0 = '0; p_ins1 = '0;
    for (int c = 0; c < 16 && c < ncyc; c++) begin
      m_cmp[c]          = t_cmp[c];
      m_ld[c]           = t_ld[c];
      m_rdy[c]          = t_rdy[c];
      m_busy[c]         = t_busy[c];
      m_done[c]         = t_done[c];
      p_ins0[4*c +: 4]  = t_ins0[c];
      p_ins1[4*c +: 4]  = t_ins1[c];
    end
  endtask

  task automatic stim_basic();
    clear_stim();
    st_v[0] = 1'b1; kl_v[0] = 8'd2;
    vv_v[2] = 1'b1; d0_v[2] = 4'd1; d1_v[2] = 4'd2;
    vv_v[3] = 1'b1; d0_v[3] = 4'd3; d1_v[3] = 4'd4;
  endtask

  task automatic check_basic(input string pfx);
    chk({pfx, "_load_en"}, 64'(m_ld),   64'h0002);
    chk({pfx, "_ready"},   64'(m_rdy),  64'h000C);
    chk({pfx, "_compute"}, 64'(m_cmp),  64'h00FC);
    chk({pfx, "_done"},    64'(m_done), 64'h0100);
    chk({pfx, "_busy"},    64'(m_busy), 64'h01FE);
    chk({pfx, "_ins0"},    p_ins0,      64'h0000_0000_0003_1000);
    chk({pfx, "_ins1"},    p_ins1,      64'h0000_0000_0042_0000);
    chk({pfx, "_hs_cnt"},  64'(hs_cnt), 64'd2);
  endtask

  int done_cyc, done_cnt;

  initial begin
    // Reset with start/valid active: nothing may leak through.
    rst = 1'b0; start = 1'b1; k_len = 8'd3; vec_valid = 1'b1;
    vec_data[0] = 4'hF; vec_data[1] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'({ins[0], ins[1], compute, load_en, vec_ready, busy, done}), 64'h0);

    // Basic job.
    stim_basic();
    run(16);
    check_basic("basic");

    // Bubble in cycle 3; junk data with valid low must not be captured.
    clear_stim();
    st_v[0] = 1'b1; kl_v[0] = 8'd2;
    vv_v[2] = 1'b1; d0_v[2] = 4'd1; d1_v[2] = 4'd2;
    vv_v[3] = 1'b0; d0_v[3] = 4'd7; d1_v[3] = 4'd7;
    vv_v[4] = 1'b1; d0_v[4] = 4'd3; d1_v[4] = 4'd4;
    run(16);
    chk("bubble_ready",   64'(m_rdy),  64'h001C);
    chk("bubble_compute", 64'(m_cmp),  64'h01FC);
    chk("bubble_done",    64'(m_done), 64'h0200);
    chk("bubble_ins0",    p_ins0,      64'h0000_0000_0030_1000);
    chk("bubble_ins1",    p_ins1,      64'h0000_0000_0402_0000);
    chk("bubble_hs_last", 64'(hs_last), 64'd4);

    // Zero-length job, valid held high the whole time.
    clear_stim();
    st_v[0] = 1'b1; kl_v[0] = 8'd0;
    for (int c = 0; c < 16; c++) begin
      vv_v[c] = 1'b1; d0_v[c] = 4'd5; d1_v[c] = 4'd5;
    end
    run(16);
    chk("zero_load_en", 64'(m_ld),   64'h0002);
    chk("zero_done",    64'(m_done), 64'h0004);
    chk("zero_busy",    64'(m_busy), 64'h0006);
    chk("zero_ready",   64'(m_rdy),  64'h0000);
    chk("zero_compute", 64'(m_cmp),  64'h0000);
    chk("zero_ins",     p_ins0 | p_ins1, 64'h0);
    chk("zero_hs_cnt",  64'(hs_cnt), 64'd0);

    // Start again mid-STREAM with k_len=5, valid kept high afterwards.
    stim_basic();
    st_v[3] = 1'b1; kl_v[3] = 8'd5;
    for (int c = 4; c < 16; c++) begin
      vv_v[c] = 1'b1; d0_v[c] = 4'd6; d1_v[c] = 4'd6;
    end
    st_v[8] = 1'b1; kl_v[8] = 8'd5;
    run(16);
    check_basic("restart");

    // Reset mid-job: rst low in cycle 3, the cycle after the first handshake.
    stim_basic();
    rs_v[3] = 1'b0;
    run(16);
    chk("rstmid_compute", 64'(m_cmp),  64'h000C);
    chk("rstmid_busy",    64'(m_busy), 64'h000E);
    chk("rstmid_ready",   64'(m_rdy),  64'h000C);
    chk("rstmid_ld_done", 64'({m_ld[15:4], m_done}), 64'h0);
    chk("rstmid_ins0_late", p_ins0 & ~64'hFFFF, 64'h0);
    chk("rstmid_ins1",    p_ins1, 64'h0);

    // Fresh job after the mid-job reset.
    stim_basic();
    run(16);
    check_basic("after_rst");

    // Maximum-length job with valid held high.
    clear_stim();
    st_v[0] = 1'b1; kl_v[0] = 8'd255;
    for (int c = 0; c < 266; c++) begin
      vv_v[c] = 1'b1; d0_v[c] = DW'(c); d1_v[c] = DW'(c + 5);
    end
    run(266);
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 0; c < 266; c++) begin
      if (t_done[c]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    chk("long_hs_cnt",   64'(hs_cnt),   64'd255);
    chk("long_hs_first", 64'(hs_first), 64'd2);
    chk("long_hs_last",  64'(hs_last),  64'd256);
    chk("long_done_cyc", 64'(done_cyc), 64'd261);
    chk("long_done_cnt", 64'(done_cnt), 64'd1);
    chk("long_ins_c100", 64'({t_ins0[100], t_ins1[100]}), 64'h37);
    chk("long_ins_c258", 64'({t_ins0[258], t_ins1[258]}), 64'h05);
    chk("long_ins_c259", 64'({t_ins0[259], t_ins1[259]}), 64'h00);
    chk("long_cmp_edge", 64'({t_cmp[256], t_cmp[260], t_cmp[261]}), 64'b110);
    chk("long_idle_end", 64'({t_busy[262], t_rdy[262]}), 64'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Activation feeder for the systolic PE array. Accepts a job of `k_len` activation vectors (one element per array row) over a valid/ready stream. Skews them so row `i` is delayed `i` cycles relative to row 0, and drives the array's `ins`, `compute` and `load_en`. It sits between the activation buffer and the array, producing the staggered wavefront the array consumes.

## Interface
- `ARRAY_SIZE`, 2: array rows, i.e. elements per activation vector.
- `COMPUTE_DATA_WIDTH`, 4: width of one activation element.
- `K_WIDTH`, 8: width of the job-length field.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset. Synchronous and active-low: sampled on the `clk` rising edge, asserted when 0.
- `start`  in  1: job start request. Honoured only in IDLE.
- `k_len`  in  `K_WIDTH`: number of vectors in the job. Sampled when `start` is accepted.
- `vec_valid`  in  1: upstream vector valid.
- `vec_data`  in  `COMPUTE_DATA_WIDTH` x `ARRAY_SIZE` (unpacked): element `i` is for row `i`.
- `vec_ready`  out  1: feeder accepts `vec_data` this cycle.
- `ins`  out  `COMPUTE_DATA_WIDTH` x `ARRAY_SIZE` (unpacked): skewed activations to the array rows. Registered.
- `compute`  out  1: array MAC enable. Registered.
- `load_en`  out  1: array load strobe. Registered.
- `busy`  out  1: a job is in progress (state is not IDLE).
- `done`  out  1: one-cycle pulse when the job completes.

## Operation
- **States:** IDLE, LOAD, STREAM, DRAIN, DONE.
- **IDLE:**
  - `start`=1 latches `k_len` into `k_rem` and moves to LOAD.
  - All other inputs are ignored.
- **LOAD:** lasts one cycle.
  - `load_en`=1 and `compute`=0.
  - Next state is STREAM if `k_rem`!=0, otherwise DONE.
- **STREAM:**
  - `vec_ready`=1 and `compute`=1 every cycle.
  - Handshake = `vec_valid` & `vec_ready` in the same cycle. Each handshake decrements `k_rem`.
  - The handshake that takes `k_rem` to 0 moves the FSM to DRAIN on the next cycle.
  - A cycle with no handshake (bubble) injects zeros into every skew lane. `compute` stays 1, and zeros are MAC-neutral.
- **DRAIN:**
  - Lasts exactly 2*`ARRAY_SIZE` cycles, counted by a drain counter.
  - `vec_ready`=0, `compute`=1, skew lanes are fed zeros. Then the FSM moves to DONE.
- **DONE:** lasts one cycle.
  - `done`=1 and `compute`=0, then the FSM returns to IDLE.
- **Skew datapath:**
  - Lane `i` is a shift register of depth `i`+1.
  - On a handshake, element `i` enters lane `i`; otherwise 0 enters.
  - `ins[i]` is the lane tail.
- `start` asserted outside IDLE is ignored. It is never queued.
- `vec_data` is captured only on a handshake. A `vec_valid` held high in IDLE, LOAD, DRAIN or DONE consumes nothing.

## Timing
- **Reset** (`rst`=0 at an edge), including mid-job:
  - State goes to IDLE; `k_rem`, the drain counter and all skew registers clear.
  - `ins`=0, `compute`=0, `load_en`=0, `vec_ready`=0, `busy`=0, `done`=0.
  - Any in-flight data is discarded.
- **Job start:** with `start` in cycle 0, `load_en` is high in cycle 1 and `vec_ready` is high from cycle 2.
- **Skew latency:** a handshake in cycle `c` drives `ins[i]` = element `i` in cycle `c`+1+`i`. Every other cycle drives `ins[i]` = 0.
- **Completion:** if the last handshake is in cycle `L`, DRAIN covers cycles `L`+1..`L`+2*`ARRAY_SIZE` and `done` is high in cycle `L`+2*`ARRAY_SIZE`+1.
- **`busy`:** 1 from the cycle after `start` through the DONE cycle inclusive.
- **`vec_ready`:** combinational from state only, never from `vec_valid`. There is no combinational path from `vec_valid` to `vec_ready`.
- **Maximum job:** `k_len`=2^`K_WIDTH`-1 is supported. `k_rem` must not wrap.
- **`k_len`=0:** IDLE -> LOAD -> DONE. `done` is in cycle 2, there are no handshakes, and `compute` never rises.

## Test plan
- **Basic job.** `ARRAY_SIZE`=2, `start` in cycle 0 with `k_len`=2, vectors [1,2] and [3,4] valid from cycle 2.
  - `load_en` is high in cycle 1; handshakes occur in cycles 2 and 3.
  - `ins[0]` = 1 in cycle 3 and 3 in cycle 4; `ins[1]` = 2 in cycle 4 and 4 in cycle 5; zeros otherwise.
  - `compute` is high in cycles 2-7 and `done` in cycle 8.
- **Bubble.** Same job, but `vec_valid` is low in cycle 3 and [3,4] is presented in cycle 4.
  - `ins[0]`=0 in cycle 4 and 3 in cycle 5.
  - `done` moves to cycle 9.
- **Zero-length job.** `k_len`=0.
  - `load_en` is high in cycle 1 and `done` in cycle 2.
  - `vec_ready` and `compute` stay 0 throughout.
- **Start while busy.** Pulse `start` again mid-STREAM with `k_len`=5.
  - The pulse is ignored; the job still completes after 2 handshakes.
  - The FSM returns to IDLE.
- **Reset mid-job.** `rst`=0 in the cycle after the first handshake.
  - All outputs are 0 in the next cycle and no `ins` data ever emerges.
  - A fresh `start` then runs the basic job correctly.
- **Long job.** `K_WIDTH`=8, `k_len`=255, `vec_valid` held high.
  - Exactly 255 handshakes occur, in consecutive cycles 2-256.
  - `done` is in cycle 261.
